sample_serializer: RTL
======================

Name: sample_serializer

Overview:
- Sits on the fx2_clk side, between the 48-bit sample FIFO read port and the FX2 byte interface.
- Pops one sample from the show-ahead FIFO and presents it as NBYTES bytes over a ready/accept handshake, least-significant byte first.
- Loads samples back-to-back with no idle cycle, so the USB link is never starved while the FIFO is non-empty.
- Keeps a wrapping count of fully transmitted samples for host diagnostics.

Parameters:
NBYTES, 6, bytes per sample; sample width is 8*NBYTES.
CNT_W, 16, width of the completed-sample counter.

Ports:
clk  input  1  FX2-domain clock (fx2_clk at the top level).
reset  input  1  asynchronous, active-high reset.
sample_rdy  input  1  FIFO not empty; sample holds valid head-of-FIFO data (show-ahead).
sample  input  8*NBYTES  head-of-FIFO sample word.
sample_ack  output  1  FIFO read request; high for exactly the cycle in which the head word is consumed.
data_rdy  output  1  byte on data is valid.
data  output  8  current byte.
data_ack  input  1  host side took the byte at this edge; ignored while data_rdy=0.
busy  output  1  a sample is held (SEND state).
samples_sent  output  CNT_W  count of samples whose last byte was accepted; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): state=IDLE, data_rdy=0, data=8'h00, idx=0, shift register=0, samples_sent=0, busy=0, sample_ack=0.
- A byte transfers on an edge where data_rdy=1 and data_ack=1.
- Load condition (combinational): (state==IDLE & sample_rdy), or (state==SEND & idx==NBYTES-1 & data_ack & sample_rdy).
- sample_ack equals the load condition and is never asserted during reset.
- On a load edge, the shift register captures sample, idx becomes 0, state becomes SEND.
- Latency: sample_rdy rising in IDLE at edge t gives sample_ack high in the cycle before edge t, and data_rdy=1 with data=sample[7:0] from t+1.
- IDLE state:
  - data_rdy=0, busy=0.
  - Go to SEND on load.
- SEND state:
  - data_rdy=1, busy=1.
  - data = byte idx of the held word, i.e. word[8*idx+7 : 8*idx]; data is driven from a registered shift or mux.
  - On accept with idx<NBYTES-1: idx increments and data shows the next byte on the following cycle.
  - On accept with idx==NBYTES-1: samples_sent increments; reload if sample_rdy, otherwise go to IDLE (data_rdy=0 next cycle).
- data_ack held high continuously: one byte per cycle, and 6 bytes per sample with no bubble between samples.
- data_ack without data_rdy: no effect.
- sample_rdy dropping mid-sample: no effect; the held copy is used.
- sample is never sampled outside a load edge.
- samples_sent wraps from 2^CNT_W-1 to 0 silently.
- Reset mid-sample: the partial sample is discarded, nothing is re-requested, and the counter clears.
- idx width is clog2(NBYTES). Values of idx at or above NBYTES are unreachable; any such value forces IDLE.

Decomposition:
- Shared package holds the state encoding (ST_IDLE, ST_SEND), SAMPLE_BYTES=6, and the byte-order constant (LSB-first).
- No sub-module is needed beyond an optional generic wrapping counter, up_counter, reused for samples_sent.

Test Plan:
- Single sample: reset, then sample=48'hfeeddeadbeed with sample_rdy, data_ack always 1 → sample_ack pulses once; data sequence ed,be,ad,de,ed,fe on 6 consecutive cycles; samples_sent=1; data_rdy drops after the last byte.
- Back-to-back: FIFO holding 48'h0000_0000_0001 then 48'h0a0b0c0d0e0f, data_ack=1 → 12 bytes with no gap: 01,00,00,00,00,00,0f,0e,0d,0c,0b,0a. sample_ack pulses twice, the second coinciding with acceptance of byte 5. samples_sent=2.
- Throttled host: data_ack pulsed every 3rd cycle → each byte held stable until accepted; no byte skipped or duplicated; sample_ack fires only at load.
- Spurious ack: data_ack=1 while IDLE with sample_rdy=0 → no state change, samples_sent unchanged, sample_ack=0.
- Reset mid-sample: assert reset after 3 bytes accepted → data_rdy=0 immediately (async); after release, the next FIFO word starts at its byte 0; samples_sent=0.
- Wrap: preload by streaming 65535 samples, then one more → samples_sent reads 0xFFFF, then 0x0000.

Source files
------------

// File: rtl/sample_serializer_pkg.sv
// Shared constants for the sample serializer: FSM encoding, default sample
// size, byte ordering and a small width helper.
package sample_serializer_pkg;

    // Bytes in one FIFO sample word.
    localparam int SAMPLE_BYTES = 6;

    // Bytes leave the serializer least-significant first.
    localparam bit BYTE_ORDER_LSB_FIRST = 1'b1;

    // FSM encoding; kept as plain constants so older tools can share it.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Byte-index width; never zero so a one-byte sample still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sample_serializer_if.sv
// FIFO read port and FX2 byte handshake grouped into one bundle.
// The serializer uses the master view, the surrounding logic the slave view.
interface sample_serializer_if
    import sample_serializer_pkg::*;
#(
    parameter int NBYTES = SAMPLE_BYTES
);
    logic                  sample_rdy;
    logic [8*NBYTES-1:0]   sample;
    logic                  sample_ack;
    logic                  data_rdy;
    logic [7:0]            data;
    logic                  data_ack;

    modport master (
        input  sample_rdy, sample, data_ack,
        output sample_ack, data_rdy, data
    );

    modport slave (
        output sample_rdy, sample, data_ack,
        input  sample_ack, data_rdy, data
    );
endinterface

// File: rtl/up_counter.sv
// Generic wrapping up-counter with enable; rolls over silently at 2^W-1.
module up_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: advance by one when enabled, natural modulo-2^W wrap.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/sample_serializer.sv
// Pops 8*NBYTES-bit samples from a show-ahead FIFO and streams them as bytes
// over a ready/accept handshake. The next sample is loaded on the same edge
// that the last byte of the current one is accepted, so a non-empty FIFO
// never produces an idle cycle on the byte side.
module sample_serializer
    import sample_serializer_pkg::*;
#(
    parameter int NBYTES = SAMPLE_BYTES,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    sample_serializer_if.master bus,
    output logic                busy,
    output logic [CNT_W-1:0]    samples_sent
);
    localparam int                IDX_W    = idx_width(NBYTES);
    localparam int                SW       = 8 * NBYTES;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SW-1:0]    shift_q, shift_d;
    logic [SW-1:0]    shift_adv;
    logic [7:0]       head_byte;

    logic send;
    logic idx_valid;
    logic last_byte;
    logic accept;
    logic accept_last;
    logic load;

    assign send        = (state_q == ST_SEND);
    assign idx_valid   = (idx_q <= LAST_IDX);
    assign last_byte   = (idx_q == LAST_IDX);
    assign accept      = send & bus.data_ack;
    assign accept_last = accept & last_byte;
    // Load from IDLE, or chain straight into the next sample on the final byte.
    assign load        = ((state_q == ST_IDLE) & bus.sample_rdy)
                       | (accept_last & bus.sample_rdy);

    // The outgoing byte always sits at one end of the held word; each accepted
    // byte shifts the next one into that position.
    generate
        if (BYTE_ORDER_LSB_FIRST) begin : g_lsb_first
            assign head_byte = shift_q[7:0];
            assign shift_adv = shift_q >> 8;
        end else begin : g_msb_first
            assign head_byte = shift_q[SW-1 -: 8];
            assign shift_adv = shift_q << 8;
        end
    endgenerate

    // Next-state: load a new word, advance one byte per accept, or drop to IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        if (load) begin
            state_d = ST_SEND;
            idx_d   = '0;
            shift_d = bus.sample;
        end else if (send) begin
            if (!idx_valid) begin
                // Out-of-range index cannot happen in normal operation; recover.
                state_d = ST_IDLE;
                idx_d   = '0;
            end else if (accept) begin
                if (last_byte) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    shift_d = shift_adv;
                end
            end
        end
    end

    // State, byte index and held sample registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Completed-sample counter for host diagnostics.
    up_counter #(
        .W (CNT_W)
    ) u_sent_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (accept_last),
        .count (samples_sent)
    );

    // The FIFO must not be popped while reset holds the FSM in IDLE.
    assign bus.sample_ack = load & ~reset;
    assign bus.data_rdy   = send;
    assign bus.data       = head_byte;
    assign busy           = send;
endmodule
